// File: rtl/serial_divider_20_16_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_divider_20_16_pkg
//  Brief    : Shared widths, counter sizing and FSM encoding for the
//             serial restoring divider.
//  Revision : 1.0  initial release
// ============================================================================
package serial_divider_20_16_pkg;

    // Default dividend/quotient and divisor/remainder widths
    localparam int DW_DEF = 20;
    localparam int VW_DEF = 16;

    // Iteration counter must be able to hold the value DW
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CW = cnt_width(DW_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : serial_divider_20_16_pkg
`default_nettype wire

// File: rtl/serial_divider_20_16_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : serial_divider_20_16_div_step
//  Brief    : One combinational restoring-division iteration. Shifts the next
//             dividend bit into the partial remainder and subtracts the
//             divisor when it fits.
//  Revision : 1.0  initial release
// ============================================================================
module serial_divider_20_16_div_step #(
    parameter int VW = 16
) (
    input  logic [VW-1:0] r_i,       // current partial remainder (always < D)
    input  logic          q_msb_i,   // dividend bit being brought down
    input  logic [VW-1:0] d_i,       // divisor
    output logic [VW-1:0] r_o,       // next partial remainder
    output logic          q_bit_o    // quotient bit produced this step
);

    logic [VW:0]   shifted;
    logic          fits;
    logic [VW-1:0] diff;

    // Compare is VW+1 bits wide so the shifted remainder never overflows.
    // The difference is only kept when it fits, and in that case it is
    // strictly below D, so VW bits of it are exact.
    always_comb begin
        shifted = {r_i, q_msb_i};
        fits    = (shifted >= {1'b0, d_i});
        diff    = shifted[VW-1:0] - d_i;
        q_bit_o = fits;
        r_o     = fits ? diff : shifted[VW-1:0];
    end

endmodule : serial_divider_20_16_div_step
`default_nettype wire

// File: rtl/serial_divider_20_16.sv
`default_nettype none
// ============================================================================
//  Module   : serial_divider_20_16
//  Brief    : Multi-cycle unsigned restoring divider, one quotient bit per
//             clock, valid/ready handshakes on operand and result sides.
//             Optional macro DIV_BY_ZERO_EN: a zero divisor bypasses the
//             iteration and reports dbz=1 one cycle after acceptance.
//  Revision : 1.0  initial release
// ============================================================================
module serial_divider_20_16
    import serial_divider_20_16_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz
);

    localparam int CNT_W = cnt_width(DW);

    state_e             state_q;
    logic [DW-1:0]      q_q;         // dividend shifting out, quotient shifting in
    logic [VW-1:0]      d_q;         // captured divisor
    logic [VW-1:0]      r_q;         // partial remainder
    logic [CNT_W-1:0]   cnt_q;       // iterations left
    logic               in_ready_q;
    logic               out_valid_q;
    logic [DW-1:0]      quotient_q;
    logic [VW-1:0]      remainder_q;
    logic               dbz_q;

    logic [VW-1:0]      r_d;
    logic               q_bit_d;
    logic [DW-1:0]      q_d;
    logic               zero_bypass;

    serial_divider_20_16_div_step #(
        .VW      (VW)
    ) u_step (
        .r_i     (r_q),
        .q_msb_i (q_q[DW-1]),
        .d_i     (d_q),
        .r_o     (r_d),
        .q_bit_o (q_bit_d)
    );

    assign q_d = {q_q[DW-2:0], q_bit_d};

`ifdef DIV_BY_ZERO_EN
    assign zero_bypass = (divisor == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    // Control FSM plus datapath registers; all outputs come straight from flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        q_q        <= dividend;
                        d_q        <= divisor;
                        r_q        <= '0;
                        cnt_q      <= CNT_W'(DW);
                        in_ready_q <= 1'b0;
                        if (zero_bypass) begin
                            // Same values the full iteration would give
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dividend[VW-1:0];
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= ST_BUSY;
                        end
                    end
                end

                ST_BUSY: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        quotient_q  <= q_d;
                        remainder_q <= r_d;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        dbz_q       <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    dbz_q       <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dbz       = dbz_q;

endmodule : serial_divider_20_16
`default_nettype wire

// File: tb/tb_serial_divider_20_16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_divider_20_16
//  Brief    : Self-checking bench for serial_divider_20_16: directed vector
//             table, handshake corner sequences and random operands against
//             a plain-arithmetic reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_divider_20_16;

    localparam int DW = 20;
    localparam int VW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          dbz;

    int n_pass  = 0;
    int n_total = 0;

    serial_divider_20_16 #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: plain integer division; divide-by-zero yields all ones and
    // the low VW bits of the dividend.
    task automatic ref_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                           output logic [DW-1:0] q, output logic [VW-1:0] r);
        if (b == '0) begin
            q = '1;
            r = a[VW-1:0];
        end else begin
            q = a / {4'b0, b};
            r = VW'(a % {4'b0, b});
        end
    endtask

    // Expected flag and cycles from accept edge (inclusive) to out_valid
    task automatic ref_timing(input logic [VW-1:0] b, output logic e_dbz, output int e_lat);
`ifdef DIV_BY_ZERO_EN
        e_dbz = (b == '0);
        e_lat = (b == '0) ? 1 : DW + 1;
`else
        e_dbz = 1'b0;
        e_lat = DW + 1;
`endif
    endtask

    task automatic run_div(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                           input logic [DW-1:0] eq, input logic [VW-1:0] er);
        logic e_dbz;
        int   e_lat;
        int   lat;
        ref_timing(b, e_dbz, e_lat);
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        chk($sformatf("%s in_ready", tag), 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
        dividend = 20'($urandom);
        divisor  = 16'($urandom);
        chk($sformatf("%s busy in_ready", tag), 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        chk($sformatf("%s latency", tag), 32'(lat), 32'(e_lat));
        chk($sformatf("%s quotient", tag), 32'(quotient), 32'(eq));
        chk($sformatf("%s remainder", tag), 32'(remainder), 32'(er));
        chk($sformatf("%s dbz", tag), 32'(dbz), 32'(e_dbz));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk($sformatf("%s consumed out_valid", tag), 32'(out_valid), 32'd0);
        chk($sformatf("%s consumed dbz", tag), 32'(dbz), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] ra, eq;
        logic [VW-1:0] rb, er;
        int            lat;

        vecs[0] = '{20'hFFFFF, 16'd9,     20'd116508,  16'd3};
        vecs[1] = '{20'd5,     16'd16,    20'd0,       16'd5};
        vecs[2] = '{20'hABCDE, 16'd1,     20'hABCDE,   16'd0};
        vecs[3] = '{20'd1234,  16'd0,     20'hFFFFF,   16'd1234};
        vecs[4] = '{20'd500,   16'd3,     20'd166,     16'd2};
        vecs[5] = '{20'hFFFFF, 16'hFFFF,  20'd16,      16'd15};
        vecs[6] = '{20'd0,     16'd5,     20'd0,       16'd0};
        vecs[7] = '{20'd65535, 16'd65535, 20'd1,       16'd0};

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset quotient", 32'(quotient), 32'd0);
        chk("reset remainder", 32'(remainder), 32'd0);
        chk("reset dbz", 32'(dbz), 32'd0);
        rst = 1'b0;
        tick();

        // Directed vector table
        for (int i = 0; i < 8; i++)
            run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

        // 100/7 with the result held under back-pressure; out_ready while BUSY ignored
        in_valid = 1'b1; dividend = 20'd100; divisor = 16'd7;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        lat = 6;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        chk("hold latency", 32'(lat), 32'(DW + 1));
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d quotient", i), 32'(quotient), 32'd14);
            chk($sformatf("hold%0d remainder", i), 32'(remainder), 32'd2);
            chk($sformatf("hold%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d in_ready", i), 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold release out_valid", 32'(out_valid), 32'd0);
        chk("hold release in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of an iteration drops the in-flight result
        in_valid = 1'b1; dividend = 20'd500; divisor = 16'd3;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst quotient", 32'(quotient), 32'd0);
        repeat (25) tick();
        chk("midrst dropped", 32'(out_valid), 32'd0);
        run_div("after_rst", 20'd500, 16'd3, 20'd166, 16'd2);

        // Back-to-back: operands change while busy, only the accepted pair counts
        in_valid = 1'b1; dividend = 20'd1000; divisor = 16'd10;
        tick();
        lat = 1;
        while (!out_valid && lat < 60) begin
            dividend = 20'($urandom);
            divisor  = 16'($urandom);
            tick();
            lat++;
        end
        chk("b2b first latency", 32'(lat), 32'(DW + 1));
        chk("b2b first quotient", 32'(quotient), 32'd100);
        chk("b2b first remainder", 32'(remainder), 32'd0);
        dividend = 20'd777; divisor = 16'd5;
        repeat (2) tick();
        chk("b2b done no capture", 32'(quotient), 32'd100);
        chk("b2b done in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("b2b idle in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b second accepted", 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        chk("b2b second quotient", 32'(quotient), 32'd155);
        chk("b2b second remainder", 32'(remainder), 32'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Random operands against the reference
        for (int i = 0; i < 40; i++) begin
            ra = 20'($urandom);
            case ($urandom_range(0, 4))
                0:       rb = 16'($urandom_range(1, 15));
                1:       rb = 16'($urandom_range(1, 255));
                2:       rb = 16'd0;
                default: rb = 16'($urandom);
            endcase
            ref_div(ra, rb, eq, er);
            run_div($sformatf("rnd%0d", i), ra, rb, eq, er);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_serial_divider_20_16
`default_nettype wire
